// File: rtl/alu_result_stage.sv
// Registered output stage for the 64-bit ALU result mux: captures Y/select/carry,
// stores ZERO/NEG flags with each entry, and drives a valid/ready port through a 2-entry skid buffer.
module alu_result_stage #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_y,
    input  logic [1:0]       in_sel,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [1:0]       out_sel,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [1:0]       sel;
        logic             carry;
        logic             zero;
        logic             neg;
    } entry_t;

    state_t           state_reg;
    entry_t           main_reg;
    entry_t           skid_reg;
    entry_t           new_entry;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             in_fire;
    logic             out_fire;

    // Flags are computed once at capture so the output register never feeds a comparator.
    always_comb begin
        new_entry.y     = in_y;
        new_entry.sel   = in_sel;
        new_entry.carry = in_carry;
        new_entry.zero  = (in_y == '0);
        new_entry.neg   = in_y[WIDTH-1];
    end

    // Ready is the registered state decode, gated only by flush (never by out_ready).
    assign in_ready = in_ready_reg & ~flush;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_reg & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            if (out_fire) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (flush) begin
                // Data registers keep their contents; only occupancy is cleared.
                state_reg     <= EMPTY;
                in_ready_reg  <= 1'b1;
                out_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    EMPTY: begin
                        in_ready_reg <= 1'b1;
                        if (in_fire) begin
                            main_reg      <= new_entry;
                            state_reg     <= ONE;
                            out_valid_reg <= 1'b1;
                        end
                    end
                    ONE: begin
                        case ({in_fire, out_fire})
                            2'b10: begin
                                skid_reg     <= new_entry;
                                state_reg    <= FULL;
                                in_ready_reg <= 1'b0;
                            end
                            2'b01: begin
                                state_reg     <= EMPTY;
                                out_valid_reg <= 1'b0;
                            end
                            2'b11: begin
                                main_reg <= new_entry;
                            end
                            default: ;
                        endcase
                    end
                    FULL: begin
                        if (out_fire) begin
                            main_reg     <= skid_reg;
                            state_reg    <= ONE;
                            in_ready_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg     <= EMPTY;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_y     = main_reg.y;
    assign out_sel   = main_reg.sel;
    assign out_carry = main_reg.carry;
    assign out_zero  = main_reg.zero;
    assign out_neg   = main_reg.neg;
    assign out_cnt   = cnt_reg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: stimulus pushes expected entries on accept,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_result_stage;

    localparam int WIDTH = 64;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_y;
    logic [1:0]       in_sel;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [1:0]       out_sel;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic [CNT_W-1:0] out_cnt;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic [1:0]       sel;
        logic             carry;
        logic             zero;
        logic             neg;
    } exp_t;

    exp_t             sb[$];
    logic [CNT_W-1:0] cnt_model;
    int               errors;
    int               checks;

    alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_sel    (in_sel),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_sel   (out_sel),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_carry (out_carry),
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one line per completed output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            cnt_model = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got y=%h with empty scoreboard, required no output", out_y);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("out y=%h sel=%b c=%b z=%b n=%b cnt=%0d", out_y, out_sel,
                             out_carry, out_zero, out_neg, out_cnt);
                    check("out_y", out_y, e.y);
                    check("out_sel", 64'(out_sel), 64'(e.sel));
                    check("out_carry", 64'(out_carry), 64'(e.carry));
                    check("out_zero", 64'(out_zero), 64'(e.zero));
                    check("out_neg", 64'(out_neg), 64'(e.neg));
                    check("out_cnt", 64'(out_cnt), 64'(cnt_model));
                end
                cnt_model = cnt_model + 1'b1;
            end
            if (flush) sb.delete();
        end
    end

    // Offer one result; called and returns at posedge+1. Expected flags are supplied by the caller.
    task automatic send(input logic [63:0] y, input logic [1:0] sel, input logic carry,
                        input logic zero, input logic neg, output int waits);
        exp_t e;
        bit   done;
        in_valid = 1'b1;
        in_y     = y;
        in_sel   = sel;
        in_carry = carry;
        waits    = 0;
        done     = 1'b0;
        while (!done && waits < 50) begin
            @(negedge clk);
            if (in_ready) begin
                e.y = y; e.sel = sel; e.carry = carry; e.zero = zero; e.neg = neg;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready for y=%h, required accept within 50 cycles", y);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          w;
        int          n;
        logic [63:0] y;

        errors    = 0;
        checks    = 0;
        cnt_model = '0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_y      = '0;
        in_sel    = '0;
        in_carry  = 1'b0;
        out_ready = 1'b0;

        // Reset / idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", out_y, 64'd0);
        check("rst_out_cnt", 64'(out_cnt), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_out_sel", 64'(out_sel), 64'd0);
        check("idle_out_flags", {61'd0, out_zero, out_neg, out_carry}, 64'd0);

        // Single pass
        out_ready = 1'b1;
        send(64'h8000_0000_0000_0000, 2'b10, 1'b1, 1'b0, 1'b1, w);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_y", out_y, 64'h8000_0000_0000_0000);
        check("single_neg", 64'(out_neg), 64'd1);
        drain();
        check("single_cnt", 64'(out_cnt), 64'd1);

        // Backpressure: 0x0 and 0x5 fill the buffer, 0x7 waits upstream
        out_ready = 1'b0;
        send(64'h0, 2'b00, 1'b0, 1'b1, 1'b0, w);
        send(64'h5, 2'b01, 1'b1, 1'b0, 1'b0, w);
        in_valid = 1'b1;
        in_y     = 64'h7;
        in_sel   = 2'b11;
        in_carry = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_y_hold", out_y, 64'h0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(64'h7, 2'b11, 1'b0, 1'b0, 1'b0, w);
        drain();
        check("bp_cnt", 64'(out_cnt), 64'd4);

        // Streaming: one result per cycle, never stalled
        for (int i = 0; i < 100; i++) begin
            y = 64'h1 << (i % 64);
            send(y, 2'(i), i[0], (y == 0), y[63], w);
            check("stream_no_stall", 64'(w), 64'd0);
        end
        drain();
        check("stream_cnt", 64'(out_cnt), 64'd104);

        // Flush while FULL
        out_ready = 1'b0;
        send(64'hA, 2'b01, 1'b0, 1'b0, 1'b0, w);
        send(64'hB, 2'b10, 1'b1, 1'b0, 1'b0, w);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_y     = 64'h99;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready_after", 64'(in_ready), 64'd1);
        check("flush_cnt", 64'(out_cnt), 64'd104);
        @(posedge clk);
        #1;

        // Counter wrap
        out_ready = 1'b1;
        n = 65535 - int'(cnt_model);
        for (int i = 0; i < n; i++) begin
            send(64'(i), 2'(i), 1'b0, (i == 0), 1'b0, w);
        end
        drain();
        check("cnt_max", 64'(out_cnt), 64'd65535);
        send(64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b1, 1'b0, 1'b1, w);
        drain();
        check("cnt_wrap", 64'(out_cnt), 64'd0);

        // Async reset with a full buffer
        out_ready = 1'b0;
        send(64'h1, 2'b00, 1'b0, 1'b0, 1'b0, w);
        send(64'h2, 2'b00, 1'b0, 1'b0, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_out_y", out_y, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage that sits directly downstream of the 4:1 result multiplexer in the 64-bit ALU datapath.
- Captures the selected result Y, together with the select code that produced it and the carry-out.
- Derives status flags from the captured result.
- Presents everything to the consumer through a valid/ready handshake, backed by a 2-entry skid buffer so that backpressure never drops a result.

Parameters:
- WIDTH, 64, datapath width of the result.
- CNT_W, 16, width of the delivered-result counter.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- FLUSH  input  1  synchronous clear of both buffer entries.
- IN_VALID  input  1  upstream result valid.
- IN_READY  output  1  stage can accept a result.
- IN_Y  input  WIDTH  result from the 4:1 mux.
- IN_SEL  input  2  {S1,S0} select code that produced IN_Y.
- IN_CARRY  input  1  carry-out associated with IN_Y.
- OUT_VALID  output  1  result available to the consumer.
- OUT_READY  input  1  consumer accepts the result.
- OUT_Y  output  WIDTH  registered result.
- OUT_SEL  output  2  registered select code.
- OUT_ZERO  output  1  1 when OUT_Y == 0.
- OUT_NEG  output  1  OUT_Y[WIDTH-1].
- OUT_CARRY  output  1  registered carry.
- OUT_CNT  output  CNT_W  number of completed output transfers.

Behaviour:
- Reset (RST_N low, asynchronous): all outputs and all internal entries go to 0, the state machine goes to EMPTY, and IN_READY = 0 while reset is asserted. Release is synchronous to CLK.
- Transfers:
  - Input transfer = IN_VALID & IN_READY at a rising edge.
  - Output transfer = OUT_VALID & OUT_READY at a rising edge.
- Flags: ZERO and NEG are computed from IN_Y at input accept and stored with the entry. They are never recomputed from the output register.
- Storage:
  - MAIN entry drives the OUT_* ports.
  - SKID entry holds a second result while the consumer stalls.
- State machine (registered):
  - EMPTY: OUT_VALID = 0, IN_READY = 1. Input transfer → load MAIN, go to ONE.
  - ONE: OUT_VALID = 1, IN_READY = 1.
    - In only → load SKID, go to FULL.
    - Out only → go to EMPTY.
    - In and out together → load MAIN with the new result, stay in ONE.
  - FULL: OUT_VALID = 1, IN_READY = 0.
    - Out transfer → move SKID to MAIN, go to ONE.
    - Otherwise hold.
- IN_READY is a registered signal decoded from the state. It must not combinationally depend on OUT_READY.
- Latency: a result accepted at edge N appears on OUT_* after edge N when the buffer was EMPTY. Throughput is 1 result/cycle while OUT_READY = 1.
- Ordering is strictly FIFO. While OUT_VALID = 1 and OUT_READY = 0, OUT_* stay stable and no entry is overwritten or dropped.
- FLUSH:
  - Takes effect at the next edge: state → EMPTY, entries invalidated.
  - IN_READY is forced to 0 combinationally during a FLUSH cycle, so no input is accepted in that cycle.
  - An output transfer coincident with FLUSH does count.
  - OUT_Y, OUT_SEL and the flags keep their last values and are don't-care while OUT_VALID = 0.
  - OUT_CNT is not cleared by FLUSH.
- OUT_CNT:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W−1 to 0 with no sticky flag.
  - Cleared only by reset.
- Reset asserted mid-transfer discards all buffered results immediately. No partial state survives.
- IN_SEL and IN_CARRY are captured alongside IN_Y with no decoding; the stage is agnostic to operation meaning.

Test Plan:
- Reset/idle: hold RST_N = 0 for 3 cycles, release with IN_VALID = 0 → OUT_VALID = 0, OUT_CNT = 0, IN_READY = 1 one cycle after release, all OUT_* = 0.
- Single pass: IN_Y = 64'h8000_0000_0000_0000, IN_SEL = 2'b10, IN_CARRY = 1, OUT_READY = 1 → next cycle OUT_Y matches, OUT_NEG = 1, OUT_ZERO = 0, OUT_CARRY = 1, OUT_SEL = 2'b10, then OUT_CNT = 1.
- Backpressure: OUT_READY = 0, offer 0x0, 0x5, 0x7 on consecutive cycles → 0x0 and 0x5 accepted, IN_READY drops to 0, 0x7 held upstream. Raise OUT_READY → outputs 0x0 (ZERO = 1), 0x5, 0x7 in order, none lost.
- Streaming: 100 back-to-back results with OUT_READY = 1 → 1 result/cycle, IN_READY never deasserts, OUT_CNT = 100.
- Flush while FULL: two results buffered, OUT_READY = 0, pulse FLUSH → next cycle OUT_VALID = 0, IN_READY = 1, OUT_CNT unchanged. A result offered during the FLUSH cycle is not accepted.
- Counter wrap and async reset: preload via 65535 transfers, one more → OUT_CNT = 0. Then assert RST_N mid-cycle with FULL buffer → OUT_VALID falls before the next clock edge.
